// File: rtl/dct_trace_pkg.sv
// rtl/dct_trace_pkg.sv - shared constants, frame layout and state encoding for the DCT sequencer
package dct_trace_pkg;

    localparam int ATOM_W          = 2;
    localparam int BUF_W           = 30;
    localparam int CNT_W           = 4;
    localparam int PAD_W           = 2;
    localparam int FRAME_W         = CNT_W + PAD_W + BUF_W;
    localparam int ATOMS_PER_FRAME = BUF_W / ATOM_W;

    // Frame layout: {dct_count, PAD, dct_buffer}
    localparam int FRAME_BUF_LSB   = 0;
    localparam int FRAME_PAD_LSB   = BUF_W;
    localparam int FRAME_CNT_LSB   = BUF_W + PAD_W;

    localparam logic [PAD_W-1:0] PAD = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_ENDING  = 3'd3,
        ST_ENDED   = 3'd4
    } dct_state_e;

endpackage

// File: rtl/dct_trace_sequencer_frame_reg.sv
// rtl/dct_trace_sequencer_frame_reg.sv - one-entry valid/ready output register for trace frames
module dct_frame_reg #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         wr_ready,
    output logic         wr_valid,
    output logic [W-1:0] wr_data,
    output logic         empty,
    output logic         load_ok
);

    // A new frame may be loaded when the slot is empty or is handing off this cycle.
    assign empty   = !wr_valid;
    assign load_ok = !wr_valid || wr_ready;

    // Hold the frame stable until the consumer takes it; a load always wins over a drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid <= 1'b0;
            wr_data  <= '0;
        end else if (load) begin
            wr_valid <= 1'b1;
            wr_data  <= load_data;
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dct_trace_sequencer.sv
// rtl/dct_trace_sequencer.sv - packs trace atoms into frames and drives the end-of-test drain
module dct_trace_sequencer
    import dct_trace_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               atom_valid,
    input  logic [ATOM_W-1:0]  atom_data,
    output logic               atom_ready,
    input  logic               flush_req,
    input  logic               test_end_req,
    output logic               wr_valid,
    output logic [FRAME_W-1:0] wr_data,
    input  logic               wr_ready,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               overflow,
    output logic               test_ending,
    output logic               test_has_ended
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ATOMS_PER_FRAME);

    dct_state_e          state_q;
    dct_state_e          state_d;
    logic                atom_accept;
    logic [CNT_W-1:0]    cnt_after;
    logic                frame_full;
    logic                draining;
    logic                frame_load;
    logic                fr_empty;
    logic                fr_load_ok;
    logic [FRAME_W-1:0]  frame_d;

    assign atom_ready  = (state_q == ST_CAPTURE) && (dct_count < FULL_COUNT);
    assign atom_accept = (state_q == ST_CAPTURE) && atom_valid && atom_ready;
    // Count as it will be once any same-cycle atom is packed.
    assign cnt_after   = dct_count + {{(CNT_W-1){1'b0}}, atom_accept};
    assign frame_full  = (dct_count == FULL_COUNT);
    assign draining    = (state_q == ST_FLUSH) || (state_q == ST_ENDING);
    // Full frames may overlap a drain; partial frames wait for an empty slot.
    assign frame_load  = (frame_full && fr_load_ok) ||
                         (draining && (dct_count != '0) && fr_empty);

    // Assemble the outgoing frame from the live buffer and count.
    always_comb begin
        frame_d = '0;
        frame_d[FRAME_BUF_LSB +: BUF_W] = dct_buffer;
        frame_d[FRAME_PAD_LSB +: PAD_W] = PAD;
        frame_d[FRAME_CNT_LSB +: CNT_W] = dct_count;
    end

    dct_frame_reg #(
        .W(FRAME_W)
    ) u_frame_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (frame_load),
        .load_data (frame_d),
        .wr_ready  (wr_ready),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .empty     (fr_empty),
        .load_ok   (fr_load_ok)
    );

    // Packing buffer: cleared when its contents move to the output register, else shifts in atoms.
    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (frame_load) begin
                dct_buffer <= '0;
                dct_count  <= '0;
            end else if (atom_accept) begin
                dct_buffer <= {dct_buffer[BUF_W-ATOM_W-1:0], atom_data};
                dct_count  <= cnt_after;
            end
            if ((state_q == ST_CAPTURE) && atom_valid && !atom_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Next-state decode; test_end_req outranks flush and enable changes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (test_end_req)      state_d = ST_ENDING;
                else if (enable)       state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (test_end_req)      state_d = ST_ENDING;
                else if (!enable)      state_d = (cnt_after != '0) ? ST_FLUSH : ST_IDLE;
                else if (flush_req && (cnt_after != '0))
                                       state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (test_end_req)      state_d = ST_ENDING;
                else if (frame_load || (dct_count == '0))
                                       state_d = enable ? ST_CAPTURE : ST_IDLE;
            end
            ST_ENDING: begin
                if ((dct_count == '0) && fr_empty)
                                       state_d = ST_ENDED;
            end
            ST_ENDED:                  state_d = ST_ENDED;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // State register with registered decodes that line up with the state they report.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            state_q        <= state_d;
            test_ending    <= (state_d == ST_ENDING);
            test_has_ended <= (state_d == ST_ENDED);
        end
    end

endmodule

// File: doc/dct_trace_sequencer.md
Name: dct_trace_sequencer

Overview:
Sequences the Nios OCI data-capture-trace (DCT) path.
- Packs 2-bit trace atoms into the 30-bit dct_buffer and keeps dct_count current.
- Hands completed or flushed frames to the trace-memory write port through a one-entry output register with a valid/ready handshake.
- Drives test_ending and test_has_ended for the OCI test bench during an orderly end-of-test drain.

Parameters:
ATOM_W, 2, width of one trace atom
BUF_W, 30, width of dct_buffer; must be a multiple of ATOM_W
CNT_W, 4, width of dct_count; 2^CNT_W - 1 >= BUF_W/ATOM_W
FRAME_W, 36, width of wr_data, laid out as {dct_count, 2'b00, dct_buffer}

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  capture enable from OCI control register
atom_valid  in  1  atom offered this cycle
atom_data  in  ATOM_W  trace atom
atom_ready  out  1  atom will be accepted this cycle
flush_req  in  1  single-cycle pulse: emit partial frame
test_end_req  in  1  single-cycle pulse: drain and end
wr_valid  out  1  frame valid to trace memory
wr_data  out  FRAME_W  frame {count, pad, buffer}
wr_ready  in  1  trace memory accepts frame
dct_buffer  out  BUF_W  current packing buffer
dct_count  out  CNT_W  number of atoms in dct_buffer (0..15)
overflow  out  1  sticky: an atom was dropped
test_ending  out  1  high while in ENDING
test_has_ended  out  1  high in ENDED

Behaviour:
- Reset (sync, active-high): all outputs 0, state IDLE, output register empty. Reset asserted mid-transfer drops the pending frame without completing the handshake.
- FSM states: IDLE, CAPTURE, FLUSH, ENDING, ENDED.
- IDLE -> CAPTURE when enable=1.
- CAPTURE -> IDLE when enable=0 and dct_count=0. If dct_count != 0 when enable falls, go to FLUSH first.
- CAPTURE -> FLUSH on flush_req with a nonzero count (count evaluated after any same-cycle atom).
- FLUSH -> CAPTURE (or IDLE if enable=0) when the partial frame has been loaded into the output register.
- ENDING is entered on test_end_req from any state except ENDED.
- ENDING -> ENDED once the buffer is empty and the output register is empty.
- ENDED is terminal until reset; test_end_req in ENDED is ignored.
- Atom acceptance:
  - Condition: state CAPTURE and atom_valid and atom_ready.
  - Effect: dct_buffer <= {dct_buffer[BUF_W-ATOM_W-1:0], atom_data}; dct_count += 1.
  - atom_ready = (state == CAPTURE) and (dct_count < 15).
- Frame completion:
  - When dct_count = 15 and the output register is empty, or is being drained in the same cycle (wr_valid && wr_ready), load wr_data = {15, 2'b00, dct_buffer}, clear the buffer and set count to 0 in the same cycle.
  - Latency: the atom that completes a frame in cycle N gives wr_valid=1 in cycle N+2 (N+1: count=15; N+2: transfer).
- Backpressure:
  - If the output register is full and not draining, the buffer holds at count 15 and atom_ready=0.
  - Any atom_valid while atom_ready=0 in CAPTURE sets overflow. Overflow stays set until reset.
  - Trace never stalls the CPU.
- Partial frames (FLUSH / ENDING):
  - Transfer {count, 2'b00, buffer} with count < 15 to the output register when it is empty, then clear the buffer.
  - flush_req with count=0 is a no-op.
- Simultaneous flush_req and atom accept: the atom is packed first, and the frame carries the incremented count.
- Simultaneous flush_req and test_end_req: test_end_req wins.
- Atoms are not accepted in FLUSH, ENDING or ENDED.
- wr_valid stays high and wr_data stays stable until wr_ready. The frame is released on the cycle wr_valid && wr_ready.
- test_ending and test_has_ended are registered decodes of the state.

Decomposition:
- Package dct_trace_pkg holds:
  - the state enum;
  - ATOMS_PER_FRAME = BUF_W/ATOM_W;
  - the frame field offsets;
  - the PAD constant 2'b00.
- One sub-module, dct_frame_reg: a one-entry valid/ready output register with load/empty signalling.

Test Plan:
- Reset, enable=1, 15 atoms 2'b01 back-to-back, wr_ready=1 -> wr_valid pulse with wr_data = {4'hF, 2'b00, 30'h15555555}, then dct_count=0 and overflow=0.
- Same as above but wr_ready=0 for 40 cycles, with a further 16 atoms offered (15 accepted into the buffer) -> buffer holds at count 15, atom_ready=0, 16th atom sets overflow=1; first frame stays stable until wr_ready=1.
- 3 atoms (2'b11, 2'b10, 2'b01), then flush_req -> wr_data = {4'd3, 2'b00, 30'h39}, state returns to CAPTURE, and dct_count=0.
- flush_req in the same cycle as the 5th atom -> frame count=5 and includes that atom.
- 7 atoms, test_end_req, wr_ready delayed 5 cycles -> test_ending=1 until partial frame {4'd7, ...} is accepted, then test_has_ended=1 and stays set despite further atoms or enable toggles.
- reset asserted while wr_valid=1 and wr_ready=0 -> next cycle all outputs 0, no frame emitted afterwards.
